// File: rtl/decode_pkg.sv
// Shared opcode constants, decode classes and the ID/EX bundle for the decode stage.
// Extends the legacy opcode.v set with the NOP encoding and the TAKEN constant.
package decode_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;

  // The all-zero word is the canonical NOP; a bubble carries its opcode/funct.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
  localparam logic [5:0]  NOP_OPCODE      = 6'h00;
  localparam logic [5:0]  NOP_FUNCT       = 6'h00;
  localparam logic        TAKEN           = 1'b1;

  typedef enum logic [2:0] {
    CLASS_NOP,
    CLASS_RTYPE,
    CLASS_LOAD,
    CLASS_STORE,
    CLASS_ALU_IMM,
    CLASS_LOGIC_IMM,
    CLASS_BRANCH,
    CLASS_OTHER
  } instr_class_e;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] dest;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  prediction;
  } id_ex_t;

  function automatic instr_class_e classify(input logic [31:0] instr);
    if (instr == NOP_INSTRUCTION) return CLASS_NOP;
    case (instr[31:26])
      OPCODE_RTYPE:                          return CLASS_RTYPE;
      OPCODE_LW:                             return CLASS_LOAD;
      OPCODE_SW:                             return CLASS_STORE;
      OPCODE_ADDI:                           return CLASS_ALU_IMM;
      OPCODE_ANDI, OPCODE_ORI, OPCODE_XORI:  return CLASS_LOGIC_IMM;
      OPCODE_BEQ, OPCODE_BNE:                return CLASS_BRANCH;
      default:                               return CLASS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Registered decode-to-execute bundle; decode drives it through the master modport.
interface decode_if;
  import decode_pkg::*;

  logic [DATA_W-1:0]     REG_PC;
  logic [DATA_W-1:0]     REG_RS_DATA;
  logic [DATA_W-1:0]     REG_RT_DATA;
  logic [DATA_W-1:0]     REG_IMM;
  logic [REG_ADDR_W-1:0] REG_DEST;
  logic [5:0]            REG_OPCODE;
  logic [5:0]            REG_FUNCT;
  logic                  reg_write;
  logic                  reg_mem_read;
  logic                  reg_mem_write;
  logic                  reg_prediction;

  modport master (
    output REG_PC, REG_RS_DATA, REG_RT_DATA, REG_IMM, REG_DEST, REG_OPCODE, REG_FUNCT,
           reg_write, reg_mem_read, reg_mem_write, reg_prediction
  );

  modport slave (
    input REG_PC, REG_RS_DATA, REG_RT_DATA, REG_IMM, REG_DEST, REG_OPCODE, REG_FUNCT,
          reg_write, reg_mem_read, reg_mem_write, reg_prediction
  );
endinterface

// File: rtl/decode_regfile.sv
// 32-entry register file: two async read ports, one write port, r0 hardwired to zero.
// DECODE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0]     rs_data,
  output logic [DATA_WIDTH-1:0]     rt_data,
  input  logic                      write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rs_fwd;
  logic                  rt_fwd;

  // NOTE: the array is deliberately left out of reset so it maps onto plain
  // storage; software must write a register before relying on its value.
  // NOTE: sequential state uses non-blocking assignment so every reader of
  // mem in this timestep sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (write_enable && write_addr != '0) mem[write_addr] <= write_data;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rs_fwd = write_enable && (write_addr == rs_addr);
  assign rt_fwd = write_enable && (write_addr == rt_addr);
`else
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
`endif

  assign rs_data = (rs_addr == '0) ? '0 : (rs_fwd ? write_data : mem[rs_addr]);
  assign rt_data = (rt_addr == '0) ? '0 : (rt_fwd ? write_data : mem[rt_addr]);

endmodule

// File: rtl/decode.sv
// Decode stage: register read, immediate extension, control decode, load-use hazard
// detection and the ID/EX pipeline register. Optional macro: DECODE_WB_BYPASS_EN.
module decode
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     PC,
  input  logic [31:0]               INSTRUCTION,
  input  logic                      prediction,
  input  logic                      flush,
  input  logic                      cache_stall,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] EX_DEST,
  input  logic                      wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
  input  logic [DATA_WIDTH-1:0]     WB_DATA,
  output logic                      hazard_stall,
  decode_if.master                  ex
);

  localparam id_ex_t BUBBLE = '{opcode: NOP_OPCODE, funct: NOP_FUNCT, default: '0};

  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [15:0]               imm;
  logic [DATA_WIDTH-1:0]     rs_data, rt_data, imm_ext;
  instr_class_e              iclass;

  logic [REG_ADDR_WIDTH-1:0] dest;
  logic reg_write, mem_read, mem_write, rs_used, rt_used, zero_ext;
  logic load_use, wb_conflict;
  id_ex_t decoded, bundle_q;

  assign rs     = INSTRUCTION[25:21];
  assign rt     = INSTRUCTION[20:16];
  assign rd     = INSTRUCTION[15:11];
  assign imm    = INSTRUCTION[15:0];
  assign iclass = classify(INSTRUCTION);

  decode_regfile #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk          (clk),
    .rs_addr      (rs),
    .rt_addr      (rt),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .write_enable (wb_write_enable),
    .write_addr   (WB_ADDR),
    .write_data   (WB_DATA)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    dest      = '0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rs_used   = 1'b1;
    rt_used   = 1'b0;
    zero_ext  = 1'b0;
    case (iclass)
      CLASS_NOP:       rs_used = 1'b0;
      CLASS_RTYPE:     begin dest = rd; reg_write = 1'b1; rt_used = 1'b1; end
      CLASS_LOAD:      begin dest = rt; reg_write = 1'b1; mem_read = 1'b1; end
      CLASS_STORE:     begin mem_write = 1'b1; rt_used = 1'b1; end
      CLASS_ALU_IMM:   begin dest = rt; reg_write = 1'b1; end
      CLASS_LOGIC_IMM: begin dest = rt; reg_write = 1'b1; zero_ext = 1'b1; end
      CLASS_BRANCH:    rt_used = 1'b1;
      default:         ;
    endcase
  end

  assign imm_ext = zero_ext ? {{(DATA_WIDTH-16){1'b0}}, imm}
                            : {{(DATA_WIDTH-16){imm[15]}}, imm};

  assign load_use = ex_mem_read && (EX_DEST != '0) &&
                    ((rs_used && rs == EX_DEST) || (rt_used && rt == EX_DEST));

  // Without forwarding, an operand written this cycle would be read stale, so
  // the instruction waits one cycle and re-reads the updated register.
`ifdef DECODE_WB_BYPASS_EN
  assign wb_conflict = 1'b0;
`else
  assign wb_conflict = wb_write_enable && (WB_ADDR != '0) &&
                       ((rs_used && rs == WB_ADDR) || (rt_used && rt == WB_ADDR));
`endif

  assign hazard_stall = !flush && (load_use || wb_conflict);

  assign decoded = '{
    pc:         PC,
    rs_data:    rs_data,
    rt_data:    rt_data,
    imm:        imm_ext,
    dest:       dest,
    opcode:     INSTRUCTION[31:26],
    funct:      INSTRUCTION[5:0],
    reg_write:  reg_write,
    mem_read:   mem_read,
    mem_write:  mem_write,
    prediction: prediction
  };

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            bundle_q <= BUBBLE;
    else if (flush)        bundle_q <= BUBBLE;
    else if (!cache_stall) bundle_q <= hazard_stall ? BUBBLE : decoded;
  end

  assign ex.REG_PC         = bundle_q.pc;
  assign ex.REG_RS_DATA    = bundle_q.rs_data;
  assign ex.REG_RT_DATA    = bundle_q.rt_data;
  assign ex.REG_IMM        = bundle_q.imm;
  assign ex.REG_DEST       = bundle_q.dest;
  assign ex.REG_OPCODE     = bundle_q.opcode;
  assign ex.REG_FUNCT      = bundle_q.funct;
  assign ex.reg_write      = bundle_q.reg_write;
  assign ex.reg_mem_read   = bundle_q.mem_read;
  assign ex.reg_mem_write  = bundle_q.mem_write;
  assign ex.reg_prediction = bundle_q.prediction;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus random stimulus against a
// behavioural model (register array + instruction-format rules).
module tb_decode;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instruction, wb_data;
  logic        prediction, flush, cache_stall, ex_mem_read, wb_write_enable;
  logic [4:0]  ex_dest, wb_addr;
  logic        hazard_stall;

  decode_if ex_if ();

  decode dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (pc),
    .INSTRUCTION     (instruction),
    .prediction      (prediction),
    .flush           (flush),
    .cache_stall     (cache_stall),
    .ex_mem_read     (ex_mem_read),
    .EX_DEST         (ex_dest),
    .wb_write_enable (wb_write_enable),
    .WB_ADDR         (wb_addr),
    .WB_DATA         (wb_data),
    .hazard_stall    (hazard_stall),
    .ex              (ex_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  dest;
    logic [5:0]  op, fn;
    logic        rw, mr, mw, pr;
  } exp_t;

  logic [31:0] mregs [32];
  exp_t        exp_q;
  int          vectors = 0;
  int          miscompares = 0;
  logic        last_hz;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [5:0]  ops [10];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e = '{default: '0};
    return e;
  endfunction

  function automatic logic [148:0] pack(input exp_t e);
    return {e.pc, e.rs, e.rt, e.imm, e.dest, e.op, e.fn, e.rw, e.mr, e.mw, e.pr};
  endfunction

  function automatic logic [148:0] observed();
    return {ex_if.REG_PC, ex_if.REG_RS_DATA, ex_if.REG_RT_DATA, ex_if.REG_IMM, ex_if.REG_DEST,
            ex_if.REG_OPCODE, ex_if.REG_FUNCT, ex_if.reg_write, ex_if.reg_mem_read,
            ex_if.reg_mem_write, ex_if.reg_prediction};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {OPCODE_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural register read as seen by an instruction in decode this cycle.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return mregs[idx];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] p, ins, input logic pred,
                                        input logic [31:0] rs_v, rt_v);
    exp_t e = '{default: '0};
    logic [5:0] op = ins[31:26];
    e.pc = p; e.rs = rs_v; e.rt = rt_v; e.op = op; e.fn = ins[5:0]; e.pr = pred;
    if (op == OPCODE_ANDI || op == OPCODE_ORI || op == OPCODE_XORI)
      e.imm = {16'h0000, ins[15:0]};
    else
      e.imm = 32'($signed(ins[15:0]));
    if (ins != 32'd0) begin
      if (op == OPCODE_RTYPE) begin e.dest = ins[15:11]; e.rw = 1'b1; end
      else if (op == OPCODE_LW) begin e.dest = ins[20:16]; e.rw = 1'b1; e.mr = 1'b1; end
      else if (op == OPCODE_ADDI || op == OPCODE_ANDI || op == OPCODE_ORI || op == OPCODE_XORI)
        begin e.dest = ins[20:16]; e.rw = 1'b1; end
      else if (op == OPCODE_SW) e.mw = 1'b1;
    end
    return e;
  endfunction

  function automatic logic model_hazard(input logic [31:0] ins, input logic fl, exr,
                                        input logic [4:0] exd, input logic we,
                                        input logic [4:0] wa);
    logic [5:0] op = ins[31:26];
    logic rs_u = (ins != 32'd0);
    logic rt_u = rs_u && (op == OPCODE_RTYPE || op == OPCODE_SW ||
                          op == OPCODE_BEQ || op == OPCODE_BNE);
    logic hit_ex = exr && exd != 5'd0 &&
                   ((rs_u && ins[25:21] == exd) || (rt_u && ins[20:16] == exd));
    logic hit_wb = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
    hit_wb = we && wa != 5'd0 && ((rs_u && ins[25:21] == wa) || (rt_u && ins[20:16] == wa));
`endif
    return !fl && (hit_ex || hit_wb);
  endfunction

  // One decode cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input logic [31:0] ins, input logic pred = 1'b0, input logic fl = 1'b0,
                      input logic cs = 1'b0, input logic exr = 1'b0, input logic [4:0] exd = 5'd0,
                      input logic we = 1'b0, input logic [4:0] wa = 5'd0,
                      input logic [31:0] wd = 32'd0);
    logic hz;
    pc_ctr = pc_ctr + 32'd4;
    pc = pc_ctr; instruction = ins; prediction = pred; flush = fl; cache_stall = cs;
    ex_mem_read = exr; ex_dest = exd; wb_write_enable = we; wb_addr = wa; wb_data = wd;
    #1;
    hz = model_hazard(ins, fl, exr, exd, we, wa);
    check("hazard_stall", {159'd0, hazard_stall}, {159'd0, hz});
    last_hz = hazard_stall;
    if (fl) exp_q = bubble();
    else if (!cs) exp_q = hz ? bubble()
                             : model_decode(pc_ctr, ins, pred, model_read(ins[25:21], we, wa, wd),
                                            model_read(ins[20:16], we, wa, wd));
    if (we && wa != 5'd0) mregs[wa] = wd;
    @(posedge clk);
    @(negedge clk);
    check("bundle", {11'd0, observed()}, {11'd0, pack(exp_q)});
  endtask

  logic [148:0] snap;

  initial begin
    ops = '{OPCODE_RTYPE, OPCODE_LW, OPCODE_SW, OPCODE_ADDI, OPCODE_ANDI,
            OPCODE_ORI, OPCODE_XORI, OPCODE_BEQ, OPCODE_BNE, 6'h3F};
    reset = 1'b0; pc = '0; instruction = '0; prediction = 1'b0; flush = 1'b0;
    cache_stall = 1'b0; ex_mem_read = 1'b0; ex_dest = '0; wb_write_enable = 1'b0;
    wb_addr = '0; wb_data = '0;
    exp_q = bubble();
    #1;
    check("reset_bundle", {11'd0, observed()}, {11'd0, pack(bubble())});
    @(negedge clk);
    reset = 1'b1;

    // Give every architectural register a known value before anything reads it.
    for (int i = 1; i < 32; i++) step(32'd0, 0, 0, 0, 0, 0, 1, 5'(i), $urandom);
    step(32'd0, 0, 0, 0, 0, 0, 1, 5'd1, 32'd5);
    step(32'd0, 0, 0, 0, 0, 0, 1, 5'd2, 32'd7);

    // Reset mid-run with a load-use pattern on the inputs.
    step(i_ins(OPCODE_ADDI, 5'd1, 5'd9, 16'h0010), 1'b1);
    reset = 1'b0;
    instruction = r_ins(5'd4, 5'd1, 5'd5, 6'h20); ex_mem_read = 1'b1; ex_dest = 5'd4;
    #1;
    check("midrun_reset_bundle", {11'd0, observed()}, {11'd0, pack(bubble())});
    check("midrun_reset_hazard", {159'd0, hazard_stall}, 160'd1);
    exp_q = bubble();
    @(negedge clk);
    reset = 1'b1;

    // ADD r3,r1,r2
    step(r_ins(5'd1, 5'd2, 5'd3, 6'h20));
    check("add_rs", {128'd0, ex_if.REG_RS_DATA}, 160'd5);
    check("add_rt", {128'd0, ex_if.REG_RT_DATA}, 160'd7);
    check("add_dest", {155'd0, ex_if.REG_DEST}, 160'd3);
    check("add_rw", {159'd0, ex_if.reg_write}, 160'd1);

    // Load-use: LW r4 in execute, ADD r5,r4,r1 in decode.
    step(r_ins(5'd4, 5'd1, 5'd5, 6'h20), 0, 0, 0, 1, 5'd4);
    check("lu_stall", {159'd0, last_hz}, 160'd1);
    check("lu_bubble_rw", {159'd0, ex_if.reg_write}, 160'd0);
    step(r_ins(5'd4, 5'd1, 5'd5, 6'h20));
    check("lu_retry_dest", {155'd0, ex_if.REG_DEST}, 160'd5);

    // Immediate extension.
    step(i_ins(OPCODE_ADDI, 5'd0, 5'd2, 16'hFFFF));
    check("addi_imm", {128'd0, ex_if.REG_IMM}, {128'd0, 32'hFFFF_FFFF});
    step(i_ins(OPCODE_ORI, 5'd0, 5'd2, 16'hFFFF));
    check("ori_imm", {128'd0, ex_if.REG_IMM}, {128'd0, 32'h0000_FFFF});

    // Flush beats a load-use match; then hold for three stalled cycles.
    step(r_ins(5'd4, 5'd1, 5'd5, 6'h20), 1, 1, 0, 1, 5'd4);
    check("flush_stall", {159'd0, last_hz}, 160'd0);
    check("flush_pred", {159'd0, ex_if.reg_prediction}, 160'd0);
    step(i_ins(OPCODE_LW, 5'd1, 5'd9, 16'h0040), 1'b1);
    snap = observed();
    for (int i = 0; i < 3; i++) begin
      step(i_ins(OPCODE_SW, 5'(i + 2), 5'd3, 16'(i)), 0, 0, 1);
      check("cache_hold", {11'd0, observed()}, {11'd0, snap});
    end

    // Writeback of r6 while decode reads it.
    step(r_ins(5'd6, 5'd0, 5'd7, 6'h20), 0, 0, 0, 0, 0, 1, 5'd6, 32'h1234);
`ifdef DECODE_WB_BYPASS_EN
    check("wb_fwd_nostall", {159'd0, last_hz}, 160'd0);
    check("wb_fwd_rs", {128'd0, ex_if.REG_RS_DATA}, 160'h1234);
`else
    check("wb_stall", {159'd0, last_hz}, 160'd1);
    step(r_ins(5'd6, 5'd0, 5'd7, 6'h20));
    check("wb_retry_rs", {128'd0, ex_if.REG_RS_DATA}, 160'h1234);
`endif

    // r0 is hardwired; BEQ writes nothing and carries the prediction.
    step(32'd0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFF);
    step(r_ins(5'd0, 5'd0, 5'd8, 6'h20));
    check("r0_read", {128'd0, ex_if.REG_RS_DATA}, 160'd0);
    step(i_ins(OPCODE_BEQ, 5'd0, 5'd0, 16'h0004), TAKEN);
    check("beq_rw", {159'd0, ex_if.reg_write}, 160'd0);
    check("beq_dest", {155'd0, ex_if.REG_DEST}, 160'd0);
    check("beq_pred", {159'd0, ex_if.reg_prediction}, 160'd1);

    // Random traffic over a small register window to provoke collisions.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ins;
      if ($urandom_range(0, 19) == 0) ins = 32'd0;
      else ins = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
      step(ins, 1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
